// File: rtl/clint_ctrl_pkg.sv
// Shared definitions for the core-local interrupt controller: widths, CSR
// addresses, FSM state encodings, default cause codes and mstatus bit indices.
package clint_ctrl_pkg;

    localparam int CPU_WIDTH      = 32;
    localparam int CSR_ADDR_WIDTH = 12;

    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_W_MEPC    = 3'd1,
        S_W_MSTATUS = 3'd2,
        S_W_MCAUSE  = 3'd3,
        S_W_MRET    = 3'd4
    } clint_state_e;

    localparam logic [CPU_WIDTH-1:0] CAUSE_ECALL_DEF  = 32'd11;
    localparam logic [CPU_WIDTH-1:0] CAUSE_EBREAK_DEF = 32'd3;
    localparam logic [CPU_WIDTH-1:0] CAUSE_TIMER_DEF  = 32'h8000_0007;

    localparam int MIE_BIT_DEF  = 3;
    localparam int MPIE_BIT_DEF = 7;

endpackage

// File: rtl/clint_ctrl.sv
// Core-local trap/interrupt controller. Detects ecall, ebreak, the timer
// interrupt and mret in EX, stalls the pipeline, sequences the mepc/mstatus/
// mcause writes on the CLINT CSR port and redirects fetch.
module clint_ctrl
    import clint_ctrl_pkg::*;
#(
    parameter logic [CPU_WIDTH-1:0] CAUSE_ECALL  = CAUSE_ECALL_DEF,
    parameter logic [CPU_WIDTH-1:0] CAUSE_EBREAK = CAUSE_EBREAK_DEF,
    parameter logic [CPU_WIDTH-1:0] CAUSE_TIMER  = CAUSE_TIMER_DEF,
    parameter int                   MIE_BIT      = MIE_BIT_DEF,
    parameter int                   MPIE_BIT     = MPIE_BIT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inst_valid_i,
    input  logic [CPU_WIDTH-1:0]      inst_addr_i,
    input  logic                      ecall_i,
    input  logic                      ebreak_i,
    input  logic                      mret_i,
    input  logic                      jump_flag_i,
    input  logic [CPU_WIDTH-1:0]      jump_addr_i,
    input  logic                      timer_int_i,
    input  logic [CPU_WIDTH-1:0]      csr_mtvec_i,
    input  logic [CPU_WIDTH-1:0]      csr_mepc_i,
    input  logic [CPU_WIDTH-1:0]      csr_mstatus_i,
    output logic                      hold_flag_o,
    output logic                      clint_csr_wr_en_o,
    output logic [CSR_ADDR_WIDTH-1:0] clint_csr_wr_adder_o,
    output logic [CPU_WIDTH-1:0]      clint_csr_wr_data_o,
    output logic                      int_assert_o,
    output logic [CPU_WIDTH-1:0]      int_addr_o
);

    localparam logic [CPU_WIDTH-1:0] INST_BYTES = 4;

    clint_state_e           state, state_next;
    logic [CPU_WIDTH-1:0]   ret_q, cause_q;
    logic                   trap_take, mret_take;
    logic [CPU_WIDTH-1:0]   ret_next, cause_next;
    logic [CPU_WIDTH-1:0]   mstatus_trap, mstatus_mret;

    // Event arbitration in IDLE; rst_n gates it so no output leaks during reset.
    // A timer trap lets the EX instruction retire, so the return address is
    // its successor (or its jump target).
    always_comb begin
        trap_take  = 1'b0;
        mret_take  = 1'b0;
        ret_next   = inst_addr_i;
        cause_next = CAUSE_ECALL;
        if (rst_n && state == S_IDLE && inst_valid_i) begin
            if (ecall_i) begin
                trap_take  = 1'b1;
                cause_next = CAUSE_ECALL;
            end else if (ebreak_i) begin
                trap_take  = 1'b1;
                cause_next = CAUSE_EBREAK;
            end else if (timer_int_i && csr_mstatus_i[MIE_BIT]) begin
                trap_take  = 1'b1;
                cause_next = CAUSE_TIMER;
                ret_next   = jump_flag_i ? jump_addr_i : inst_addr_i + INST_BYTES;
            end else if (mret_i) begin
                mret_take  = 1'b1;
            end
        end
    end

    // State register plus return-address/cause latches captured on trap entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ret_q   <= '0;
            cause_q <= '0;
        end else begin
            state <= state_next;
            if (trap_take) begin
                ret_q   <= ret_next;
                cause_q <= cause_next;
            end
        end
    end

    // Next-state logic: trap walks mepc -> mstatus -> mcause, mret is one step.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (trap_take)      state_next = S_W_MEPC;
                else if (mret_take) state_next = S_W_MRET;
            end
            S_W_MEPC:    state_next = S_W_MSTATUS;
            S_W_MSTATUS: state_next = S_W_MCAUSE;
            S_W_MCAUSE:  state_next = S_IDLE;
            S_W_MRET:    state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // mstatus images: trap stacks MIE into MPIE and masks; mret restores MIE.
    always_comb begin
        mstatus_trap           = csr_mstatus_i;
        mstatus_trap[MPIE_BIT] = csr_mstatus_i[MIE_BIT];
        mstatus_trap[MIE_BIT]  = 1'b0;
        mstatus_mret           = csr_mstatus_i;
        mstatus_mret[MIE_BIT]  = csr_mstatus_i[MPIE_BIT];
        mstatus_mret[MPIE_BIT] = 1'b1;
    end

    // Output decode per state; everything defaults to zero.
    always_comb begin
        hold_flag_o          = 1'b0;
        clint_csr_wr_en_o    = 1'b0;
        clint_csr_wr_adder_o = '0;
        clint_csr_wr_data_o  = '0;
        int_assert_o         = 1'b0;
        int_addr_o           = '0;
        case (state)
            S_IDLE: begin
                hold_flag_o = trap_take | mret_take;
            end
            S_W_MEPC: begin
                hold_flag_o          = 1'b1;
                clint_csr_wr_en_o    = 1'b1;
                clint_csr_wr_adder_o = CSR_MEPC;
                clint_csr_wr_data_o  = ret_q;
            end
            S_W_MSTATUS: begin
                hold_flag_o          = 1'b1;
                clint_csr_wr_en_o    = 1'b1;
                clint_csr_wr_adder_o = CSR_MSTATUS;
                clint_csr_wr_data_o  = mstatus_trap;
            end
            S_W_MCAUSE: begin
                hold_flag_o          = 1'b1;
                clint_csr_wr_en_o    = 1'b1;
                clint_csr_wr_adder_o = CSR_MCAUSE;
                clint_csr_wr_data_o  = cause_q;
                int_assert_o         = 1'b1;
                int_addr_o           = csr_mtvec_i;
            end
            S_W_MRET: begin
                hold_flag_o          = 1'b1;
                clint_csr_wr_en_o    = 1'b1;
                clint_csr_wr_adder_o = CSR_MSTATUS;
                clint_csr_wr_data_o  = mstatus_mret;
                int_assert_o         = 1'b1;
                int_addr_o           = csr_mepc_i;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/clint_ctrl.md
Name: clint_ctrl

Overview:
Core-local interrupt/trap controller sitting directly upstream of the CSR register file. It detects synchronous traps (ecall, ebreak), the asynchronous timer interrupt and mret in the execute stage, and stalls the pipeline. It sequences the mepc/mstatus/mcause writes over the dedicated CLINT CSR write port, then redirects fetch to mtvec (trap) or mepc (mret). It reads mtvec, mepc and mstatus from the CSR file's direct outputs.

Parameters:
CAUSE_ECALL, 32'd11, mcause value written for ecall
CAUSE_EBREAK, 32'd3, mcause value written for ebreak
CAUSE_TIMER, 32'h8000_0007, mcause value written for the timer interrupt
MIE_BIT, 3, mstatus global interrupt enable bit
MPIE_BIT, 7, mstatus previous interrupt enable bit

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
inst_valid_i  in  1  valid instruction in EX
inst_addr_i  in  CPU_WIDTH  PC of the EX instruction
ecall_i  in  1  EX instruction is ecall
ebreak_i  in  1  EX instruction is ebreak
mret_i  in  1  EX instruction is mret
jump_flag_i  in  1  EX instruction redirects fetch
jump_addr_i  in  CPU_WIDTH  EX redirect target
timer_int_i  in  1  level timer interrupt request
csr_mtvec_i  in  CPU_WIDTH  current mtvec
csr_mepc_i  in  CPU_WIDTH  current mepc
csr_mstatus_i  in  CPU_WIDTH  current mstatus
hold_flag_o  out  1  stall the whole pipeline
clint_csr_wr_en_o  out  1  CSR write strobe
clint_csr_wr_adder_o  out  CSR_ADDR_WIDTH  CSR write address
clint_csr_wr_data_o  out  CPU_WIDTH  CSR write data
int_assert_o  out  1  one-cycle fetch redirect
int_addr_o  out  CPU_WIDTH  redirect target

Behaviour:
- Reset (async, mid-operation included): state=IDLE, return-address/cause latches=0, all outputs 0.
- States: IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, W_MRET.
- Event priority in IDLE, sampled only when inst_valid_i=1: ecall > ebreak > timer > mret.
  - Timer is accepted only if timer_int_i=1 and csr_mstatus_i[MIE_BIT]=1.
  - With inst_valid_i=0, no event is taken.
- Sync trap at cycle T:
  - Latch ret=inst_addr_i and cause=CAUSE_ECALL or CAUSE_EBREAK.
  - Next state W_MEPC.
- Timer trap at cycle T:
  - The EX instruction retires first.
  - Latch ret=jump_flag_i ? jump_addr_i : inst_addr_i+4, and cause=CAUSE_TIMER.
  - Next state W_MEPC.
- mret at T: next state W_MRET.
- hold_flag_o=1 in IDLE on the accepting cycle (combinational) and in every non-IDLE state; 0 otherwise.
- W_MEPC (T+1): wr_en=1, addr=CSR_MEPC, data=ret. Next state W_MSTATUS.
- W_MSTATUS (T+2): wr_en=1, addr=CSR_MSTATUS, data=csr_mstatus_i with bit MPIE=old MIE and bit MIE=0. Next state W_MCAUSE.
- W_MCAUSE (T+3): wr_en=1, addr=CSR_MCAUSE, data=cause. Also int_assert_o=1 and int_addr_o=csr_mtvec_i. Next state IDLE.
- W_MRET (T+1): wr_en=1, addr=CSR_MSTATUS, data=csr_mstatus_i with MIE=old MPIE and MPIE=1. Also int_assert_o=1 and int_addr_o=csr_mepc_i. Next state IDLE.
- Outside the states above: wr_en=0, addr=0, data=0, int_assert_o=0, int_addr_o=0.
- All events arriving in non-IDLE states are ignored; the pipeline is held so EX inputs are stable.
  - The timer is level-sensitive, so a still-pending request is re-evaluated in IDLE.
  - It is normally masked there because MIE=0.
- Arithmetic: ret = inst_addr_i+4 is modulo 2^CPU_WIDTH (32'hFFFF_FFFC wraps to 0).
- Latency: trap takes 4 hold cycles with redirect on the 4th; mret takes 2 hold cycles with redirect on the 2nd.

Decomposition:
- Shared defines file (already holding the CSR_* addresses and widths) gains:
  - state encodings
  - cause codes as the parameter defaults
  - MIE/MPIE bit indices
- No sub-module; single FSM plus latches.

Test Plan:
- ecall at inst_addr_i=32'h100, mtvec=32'h200, mstatus=32'h8:
  - T+1 writes mepc=32'h100.
  - T+2 writes mstatus=32'h80.
  - T+3 writes mcause=11, with int_assert_o=1 and int_addr_o=32'h200.
  - hold_flag_o=1 for T..T+3.
- timer_int_i=1, mstatus=32'h8, inst_addr_i=32'h40, jump_flag_i=0 -> mepc=32'h44, mcause=32'h8000_0007. Repeat with jump_flag_i=1, jump_addr_i=32'h80 -> mepc=32'h80.
- timer_int_i=1 with mstatus=0 -> no hold, no writes. Timer plus ecall in the same cycle -> mcause=11.
- mret with mstatus=32'h80, mepc=32'h104 -> T+1 writes mstatus=32'h88, with int_assert_o=1 and int_addr_o=32'h104. hold_flag_o=1 for 2 cycles.
- Timer with inst_addr_i=32'hFFFF_FFFC, jump_flag_i=0 -> mepc=0.
- rst_n low during W_MSTATUS -> all outputs 0 immediately. After release, no residual writes occur, and a new ecall restarts at W_MEPC.
